driver_display: RTL and testbench
=================================

// Module: driver_display
// PURPOSE
//  Downstream output stage of maquina_de_vendas. Drives the 4-digit multiplexed
//  7-segment display (segmentos, D1..D4) from the values the vending core produces:
//  - selected product code
//  - product price
//  - accumulated credit
//  - main-FSM mode
//  Scans one digit at a time, freezes inputs per frame to avoid tearing, and blinks
//  during dispense.
// PARAMETERS
//  DIV_SCAN      12500  clk cycles per digit slot (50 MHz -> 4 kHz slot, 1 kHz frame)
//  BLANK_CYC     16     cycles at start of each slot with all digits off (anti-ghosting)
//  BLINK_FRAMES  250    frames per blink half-period (2 Hz at defaults)
// PORTS
//  clk             in   1  system clock, rising edge
//  reset           in   1  asynchronous reset, active-low
//  codigo_produto  in   4  selected product code, binary 0..15
//  preco           in   3  price of selected product, binary 0..7
//  valor_acumulado in   4  credit inserted, binary 0..15
//  modo            in   2  0=OCIOSO 1=SELECAO 2=PAGAMENTO 3=LIBERANDO
//  segmentos       out  8  active-low; [7]=dp, [6:0]=g,f,e,d,c,b,a
//  D1,D2,D3,D4     out  1  digit enables, active-low; D1 = leftmost
// BEHAVIOUR
//  Reset (reset=0, async): segmentos=8'hFF, D1..D4=1, slot counter=0, digit idx=0,
//   frame-blink counter=0, blink phase=ON, shadow regs=0 (shadow modo=OCIOSO).
//  Slot counter: counts 0..DIV_SCAN-1, wraps to 0.
//   - At wrap, idx advances 0->1->2->3->0.
//   - At idx 3->0 (frame boundary), shadow regs capture all four inputs in that same
//     edge, and the blink counter increments.
//   - Blink counter wraps at BLINK_FRAMES-1 and toggles the blink phase.
//  Inputs are used only through the shadow regs. A mid-frame change appears at the
//   next frame boundary, never within a frame.
//  Outputs are registered, with 1 clk latency from the idx/slot-counter state they
//   decode. Exactly one D low, or none.
//  Blanking: while slot counter < BLANK_CYC, D1..D4=1 and segmentos=FF.
//   BLANK_CYC >= DIV_SCAN is illegal.
//  Digit content by shadow modo (decimal, tens then units):
//   - OCIOSO: all four digits show dash (8'hBF).
//   - SELECAO: D1,D2 = codigo_produto 00..15; D3,D4 blank (FF).
//   - PAGAMENTO: D1,D2 = preco 00..07, dp lit on D2; D3,D4 = valor_acumulado 00..15.
//   - LIBERANDO: D3,D4 = valor_acumulado; D1,D2 blank. When blink phase=OFF, all D
//     are held 1.
//  Bin->BCD for 4-bit value v: tens = (v>=10), units = v - 10*tens.
//   A leading zero is shown, not suppressed.
//  Glyphs, active-low:
//   0=C0 1=F9 2=A4 3=B0 4=99 5=92 6=82 7=F8 8=80 9=90 dash=BF blank=FF.
//   dp lit = bit7 cleared.
//  Reset asserted mid-slot returns all outputs to reset values asynchronously.
//   Scanning restarts at idx 0, slot counter 0 on the first clk after release.
// STRUCTURE
//  Shared package: modo encodings; glyph constants (SEG_BLANK, SEG_DASH, digit table);
//   default DIV_SCAN/BLANK_CYC.
//  Sub-module: decod7seg (4-bit digit + dp -> 8-bit active-low pattern).
//   Instantiated once, on the muxed digit.
//  Everything else (counters, shadow regs, mux, output regs) is in driver_display.
// TESTING (bench uses DIV_SCAN=8, BLANK_CYC=2, BLINK_FRAMES=2)
//  1. Hold reset low 5 clk -> segmentos=FF, D1..D4=1111. Release -> first D1=0 no
//     earlier than cycle BLANK_CYC+1.
//  2. modo=PAGAMENTO, preco=5, valor_acumulado=13 for 1 frame, then frame 2 ->
//     D1:C0, D2:12 (dp+5), D3:F9, D4:B0. Each digit low for DIV_SCAN-BLANK_CYC cycles,
//     in order D1..D4.
//  3. Change valor_acumulado 13->7 at idx=2 mid-frame -> rest of frame still shows 13;
//     next frame D3=C0, D4=F8.
//  4. modo=OCIOSO -> all four slots drive BF. modo=SELECAO, codigo_produto=10 ->
//     D1=F9, D2=C0, D3/D4 slots segmentos=FF.
//  5. modo=LIBERANDO, valor_acumulado=4 -> 2 frames D3=C0/D4=99 visible, then 2 frames
//     all D=1, repeating.
//  6. Assert reset during idx=3 slot -> outputs FF/1111 immediately, without a clk edge;
//     after release, scan restarts at D1.

Source files
------------

// File: rtl/driver_display_pkg.sv
// Shared definitions for the vending-machine display driver: mode codes,
// segment glyphs, default timing and the binary-to-BCD helpers.
package driver_display_pkg;

   typedef enum logic [1:0] {
      MODO_OCIOSO    = 2'd0,
      MODO_SELECAO   = 2'd1,
      MODO_PAGAMENTO = 2'd2,
      MODO_LIBERANDO = 2'd3
   } modo_e;

   // What the current slot shows before segment encoding.
   typedef enum logic [1:0] {
      SRC_DIGIT,
      SRC_DASH,
      SRC_BLANK
   } src_e;

   typedef struct packed {
      logic [3:0] codigo;
      logic [2:0] preco;
      logic [3:0] valor;
      modo_e      modo;
   } shadow_t;

   localparam int DEF_DIV_SCAN     = 12500;
   localparam int DEF_BLANK_CYC    = 16;
   localparam int DEF_BLINK_FRAMES = 250;

   localparam logic [7:0] SEG_BLANK = 8'hFF;
   localparam logic [7:0] SEG_DASH  = 8'hBF;

   // Digit table, active-low g..a; anything above 9 renders blank.
   function automatic logic [6:0] digit_glyph(input logic [3:0] d);
      case (d)
         4'd0:    return 7'h40;
         4'd1:    return 7'h79;
         4'd2:    return 7'h24;
         4'd3:    return 7'h30;
         4'd4:    return 7'h19;
         4'd5:    return 7'h12;
         4'd6:    return 7'h02;
         4'd7:    return 7'h78;
         4'd8:    return 7'h00;
         4'd9:    return 7'h10;
         default: return 7'h7F;
      endcase
   endfunction

   function automatic logic [3:0] bcd_tens(input logic [3:0] v);
      return (v >= 4'd10) ? 4'd1 : 4'd0;
   endfunction

   function automatic logic [3:0] bcd_units(input logic [3:0] v);
      return (v >= 4'd10) ? (v - 4'd10) : v;
   endfunction

endpackage

// File: rtl/driver_display_decod7seg.sv
// Single-digit decoder: BCD digit plus decimal point to an active-low
// 8-bit segment pattern {dp, g, f, e, d, c, b, a}.
module decod7seg
   import driver_display_pkg::*;
(
   input  logic [3:0] digit_i,
   input  logic       dp_i,
   output logic [7:0] seg_o
);

   assign seg_o = {~dp_i, digit_glyph(digit_i)};

endmodule

// File: rtl/driver_display.sv
// Multiplexed 4-digit 7-segment driver: scans D1..D4, latches its inputs once
// per frame so a digit never tears, and blinks the credit while dispensing.
module driver_display
   import driver_display_pkg::*;
#(
   parameter int DIV_SCAN     = DEF_DIV_SCAN,
   parameter int BLANK_CYC    = DEF_BLANK_CYC,
   parameter int BLINK_FRAMES = DEF_BLINK_FRAMES
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] codigo_produto,
   input  logic [2:0] preco,
   input  logic [3:0] valor_acumulado,
   input  logic [1:0] modo,
   output logic [7:0] segmentos,
   output logic       D1,
   output logic       D2,
   output logic       D3,
   output logic       D4
);

   localparam int SLOT_W  = (DIV_SCAN > 1) ? $clog2(DIV_SCAN) : 1;
   localparam int BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   if (BLANK_CYC >= DIV_SCAN) begin : g_bad_cfg
      $error("driver_display: BLANK_CYC must be smaller than DIV_SCAN");
   end

   logic [SLOT_W-1:0]  slot_q;
   logic [1:0]         idx_q;
   logic [BLINK_W-1:0] blink_cnt_q;
   logic               blink_on_q;
   shadow_t            shadow_q;
   logic [7:0]         seg_q, seg_d;
   logic [3:0]         dig_n_q, dig_n_d;

   logic       slot_wrap, frame_end, show;
   src_e       src;
   logic [3:0] digit;
   logic       dp;
   logic [7:0] seg_digit;

   assign slot_wrap = (slot_q == SLOT_W'(DIV_SCAN - 1));
   assign frame_end = slot_wrap && (idx_q == 2'd3);

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      src   = SRC_BLANK;
      digit = 4'd0;
      dp    = 1'b0;
      show  = 1'b1;
      case (shadow_q.modo)
         MODO_OCIOSO: src = SRC_DASH;
         MODO_SELECAO: begin
            if (idx_q == 2'd0) begin
               src   = SRC_DIGIT;
               digit = bcd_tens(shadow_q.codigo);
            end else if (idx_q == 2'd1) begin
               src   = SRC_DIGIT;
               digit = bcd_units(shadow_q.codigo);
            end
         end
         MODO_PAGAMENTO: begin
            src = SRC_DIGIT;
            case (idx_q)
               2'd0: digit = bcd_tens({1'b0, shadow_q.preco});
               2'd1: begin
                  digit = bcd_units({1'b0, shadow_q.preco});
                  dp    = 1'b1;
               end
               2'd2: digit = bcd_tens(shadow_q.valor);
               default: digit = bcd_units(shadow_q.valor);
            endcase
         end
         default: begin
            show = blink_on_q;
            if (idx_q == 2'd2) begin
               src   = SRC_DIGIT;
               digit = bcd_tens(shadow_q.valor);
            end else if (idx_q == 2'd3) begin
               src   = SRC_DIGIT;
               digit = bcd_units(shadow_q.valor);
            end
         end
      endcase
   end

   decod7seg u_decod7seg (
      .digit_i (digit),
      .dp_i    (dp),
      .seg_o   (seg_digit)
   );

   // Anti-ghosting gap at the start of each slot, and the blink-off phase,
   // both turn every digit off.
   always_comb begin
      seg_d   = SEG_BLANK;
      dig_n_d = 4'hF;
      if (slot_q >= SLOT_W'(BLANK_CYC) && show) begin
         dig_n_d = ~(4'b0001 << idx_q);
         case (src)
            SRC_DIGIT: seg_d = seg_digit;
            SRC_DASH:  seg_d = SEG_DASH;
            default:   seg_d = SEG_BLANK;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         slot_q      <= '0;
         idx_q       <= 2'd0;
         blink_cnt_q <= '0;
         blink_on_q  <= 1'b1;
         shadow_q    <= '{codigo: 4'd0, preco: 3'd0, valor: 4'd0, modo: MODO_OCIOSO};
         seg_q       <= SEG_BLANK;
         dig_n_q     <= 4'hF;
      end else begin
         seg_q   <= seg_d;
         dig_n_q <= dig_n_d;
         slot_q  <= slot_wrap ? '0 : slot_q + SLOT_W'(1);
         if (slot_wrap) idx_q <= idx_q + 2'd1;
         if (frame_end) begin
            shadow_q <= '{codigo: codigo_produto, preco: preco,
                          valor: valor_acumulado, modo: modo_e'(modo)};
            if (blink_cnt_q == BLINK_W'(BLINK_FRAMES - 1)) begin
               blink_cnt_q <= '0;
               blink_on_q  <= ~blink_on_q;
            end else begin
               blink_cnt_q <= blink_cnt_q + BLINK_W'(1);
            end
         end
      end
   end

   assign segmentos        = seg_q;
   assign {D4, D3, D2, D1} = dig_n_q;

endmodule

// File: tb/tb_driver_display.sv
// Directed bench for driver_display with a short scan (8-cycle slots,
// 2-cycle blanking, 2-frame blink half-period).
module tb_driver_display;
   import driver_display_pkg::*;

   localparam int DIV   = 8;
   localparam int BLANK = 2;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] codigo_produto;
   logic [2:0] preco;
   logic [3:0] valor_acumulado;
   logic [1:0] modo;
   logic [7:0] segmentos;
   logic       D1, D2, D3, D4;

   int checks   = 0;
   int failures = 0;
   int frame_no = 0;

   always #5 clk = ~clk;

   driver_display #(
      .DIV_SCAN     (DIV),
      .BLANK_CYC    (BLANK),
      .BLINK_FRAMES (2)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .codigo_produto  (codigo_produto),
      .preco           (preco),
      .valor_acumulado (valor_acumulado),
      .modo            (modo),
      .segmentos       (segmentos),
      .D1              (D1),
      .D2              (D2),
      .D3              (D3),
      .D4              (D4)
   );

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   // One digit slot: blanking cycles first, then the digit itself.
   task automatic check_slot(input string name, input int idx, input logic [7:0] exp_seg,
                             input logic chk_seg, input logic on, input logic chk_d);
      for (int j = 0; j < DIV; j++) begin
         logic [7:0] es;
         logic [3:0] ed;
         logic       cs, cd;
         step();
         if (j < BLANK) begin
            es = 8'hFF; ed = 4'hF; cs = 1'b1; cd = 1'b1;
         end else begin
            es = exp_seg; ed = on ? ~(4'b0001 << idx) : 4'hF; cs = chk_seg; cd = chk_d;
         end
         checks++;
         if ((cs && segmentos !== es) || (cd && {D4, D3, D2, D1} !== ed)) begin
            failures++;
            $display("FAIL %s frame%0d slot%0d cyc%0d: got seg=%h D4..D1=%b, want seg=%h D4..D1=%b",
                     name, frame_no, idx, j, segmentos, {D4, D3, D2, D1}, es, ed);
         end
      end
   endtask

   task automatic check_frame(input string name, input logic [31:0] segs,
                              input logic [3:0] chk_seg, input logic [3:0] on,
                              input logic [3:0] chk_d);
      for (int i = 0; i < 4; i++)
         check_slot(name, i, segs[31-8*i -: 8], chk_seg[i], on[i], chk_d[i]);
      frame_no++;
   endtask

   task automatic frame_all(input string name, input logic [31:0] segs);
      check_frame(name, segs, 4'hF, 4'hF, 4'hF);
   endtask

   task automatic test_reset();
      reset = 1'b0;
      codigo_produto = 4'd0; preco = 3'd0; valor_acumulado = 4'd0; modo = MODO_OCIOSO;
      repeat (5) @(negedge clk);
      checks++;
      if (segmentos !== 8'hFF || {D4, D3, D2, D1} !== 4'hF) begin
         failures++;
         $display("FAIL reset_hold: got seg=%h D4..D1=%b, want seg=ff D4..D1=1111",
                  segmentos, {D4, D3, D2, D1});
      end
      reset = 1'b1;
      frame_no = 0;
      frame_all("reset_first_frame", {8'hBF, 8'hBF, 8'hBF, 8'hBF});
   endtask

   task automatic test_pagamento();
      modo = MODO_PAGAMENTO; preco = 3'd5; valor_acumulado = 4'd13;
      frame_all("pag_latency", {8'hBF, 8'hBF, 8'hBF, 8'hBF});
      frame_all("pag_shown", {8'hC0, 8'h12, 8'hF9, 8'hB0});
   endtask

   task automatic test_midframe();
      check_slot("mid_d1", 0, 8'hC0, 1'b1, 1'b1, 1'b1);
      check_slot("mid_d2", 1, 8'h12, 1'b1, 1'b1, 1'b1);
      valor_acumulado = 4'd7;
      check_slot("mid_d3_old", 2, 8'hF9, 1'b1, 1'b1, 1'b1);
      check_slot("mid_d4_old", 3, 8'hB0, 1'b1, 1'b1, 1'b1);
      frame_no++;
      frame_all("mid_next_frame", {8'hC0, 8'h12, 8'hC0, 8'hF8});
   endtask

   task automatic test_ocioso_selecao();
      modo = MODO_OCIOSO;
      frame_all("ocioso_latency", {8'hC0, 8'h12, 8'hC0, 8'hF8});
      modo = MODO_SELECAO; codigo_produto = 4'd10;
      frame_all("ocioso_dash", {8'hBF, 8'hBF, 8'hBF, 8'hBF});
      check_frame("selecao", {8'hF9, 8'hC0, 8'hFF, 8'hFF}, 4'hF, 4'hF, 4'b0011);
   endtask

   task automatic test_liberando();
      modo = MODO_LIBERANDO; valor_acumulado = 4'd4;
      check_frame("lib_latency", {8'hF9, 8'hC0, 8'hFF, 8'hFF}, 4'hF, 4'hF, 4'b0011);
      // Phase starts ON and flips every second frame boundary since reset.
      for (int f = 0; f < 7; f++) begin
         if (((frame_no / 2) % 2) == 0)
            check_frame("lib_on", {8'hFF, 8'hFF, 8'hC0, 8'h99}, 4'hF, 4'hF, 4'b1100);
         else
            check_frame("lib_off", {8'hFF, 8'hFF, 8'hFF, 8'hFF}, 4'h0, 4'h0, 4'hF);
      end
   endtask

   task automatic test_reset_mid_slot();
      check_slot("rst_pre_d1", 0, 8'hFF, 1'b1, 1'b1, 1'b0);
      check_slot("rst_pre_d2", 1, 8'hFF, 1'b1, 1'b1, 1'b0);
      check_slot("rst_pre_d3", 2, 8'hC0, 1'b1, 1'b1, 1'b1);
      repeat (4) step();
      checks++;
      if (segmentos !== 8'h99 || {D4, D3, D2, D1} !== 4'b0111) begin
         failures++;
         $display("FAIL rst_pre_d4: got seg=%h D4..D1=%b, want seg=99 D4..D1=0111",
                  segmentos, {D4, D3, D2, D1});
      end
      #2 reset = 1'b0;
      #1;
      checks++;
      if (segmentos !== 8'hFF || {D4, D3, D2, D1} !== 4'hF) begin
         failures++;
         $display("FAIL rst_async: got seg=%h D4..D1=%b, want seg=ff D4..D1=1111",
                  segmentos, {D4, D3, D2, D1});
      end
      repeat (2) @(negedge clk);
      reset = 1'b1;
      frame_no = 0;
      frame_all("rst_restart", {8'hBF, 8'hBF, 8'hBF, 8'hBF});
   endtask

   initial begin
      test_reset();
      test_pagamento();
      test_midframe();
      test_ocioso_selecao();
      test_liberando();
      test_reset_mid_slot();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
